conv_result_serializer: RTL
===========================

Name: conv_result_serializer

Overview:
- Downstream stage of the 8x8-tap, 4-bit convolution block.
- Captures the 15 parallel 4-bit result words and streams them out one word per transfer over a valid/ready interface, with an index, a last flag and a running checksum.
- Decouples the purely combinational convolver from a narrow, back-pressured consumer such as a UART or display driver.

Parameters:
- N_OUT, 15, number of result words per frame (2*8-1).
- W, 4, bits per result word.
- IDX_W, 4, width of the word index; must satisfy 2^IDX_W >= N_OUT.
- CK_W, 8, checksum width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- y_flat  input  N_OUT*W  convolution results; word k occupies y_flat[W*k+W-1 : W*k].
- start  input  1  request to capture y_flat and send one frame.
- abort  input  1  synchronous frame cancel.
- busy  output  1  high while a captured frame is being sent.
- m_valid  output  1  m_data, m_index and m_last are valid.
- m_ready  input  1  consumer accepts the word.
- m_data  output  W  current result word.
- m_index  output  IDX_W  index of the current word, 0..N_OUT-1.
- m_last  output  1  high with m_valid when m_index == N_OUT-1.
- done  output  1  one-cycle pulse after the final word transfers.
- checksum  output  CK_W  sum mod 2^CK_W of the transferred words; holds its value until the next capture.

Behaviour:
- Clock and reset
  - One clock domain.
  - rst_n low asynchronously forces state=IDLE and clears the capture register and every output.
  - Reset values: busy=0, m_valid=0, m_data=0, m_index=0, m_last=0, done=0, checksum=0.
- State IDLE
  - busy=0, m_valid=0.
  - start high at an edge: y_flat copied into an internal N_OUT*W register, index cleared, checksum cleared, state goes to SEND.
  - After capture, y_flat changes have no effect on the frame in flight.
- State SEND
  - busy=1, m_valid=1.
  - m_data = captured word[index]; m_last = (index == N_OUT-1).
  - First m_valid occurs in the cycle after start is sampled (latency 1).
- Transfer rule
  - A transfer is m_valid && m_ready at a rising edge.
  - On each transfer: checksum += zero-extended m_data, then index increments.
  - While m_valid && !m_ready: m_data, m_index and m_last hold stable. No word is dropped or repeated.
- End of frame
  - Transfer with m_last=1: state returns to IDLE, m_valid drops the next cycle, and done=1 for exactly that one cycle.
  - checksum then shows the full frame sum.
- Back-to-back frames
  - start sampled high while done=1 (state already IDLE) is accepted.
  - The next frame's word 0 is valid the following cycle.
  - That capture clears checksum one cycle after done.
- start while busy: ignored and not queued.
- abort
  - Abort high at an edge in SEND: return to IDLE, m_valid=0 next cycle, no done pulse.
  - checksum keeps its partial sum.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: abort wins and there is no capture.
- Arithmetic
  - checksum wraps modulo 2^CK_W.
  - For N_OUT=15 and W=4 the maximum sum is 225, so it never wraps at the defaults.
- Throughput: with m_ready held high, one word per cycle. Start to done is N_OUT+1 cycles (16 at the defaults).
- Reset mid-frame: the frame is abandoned, all outputs return to reset values immediately, and no done pulse is produced.

Test Plan:
- Reset, then y_flat with word k = k (0..14), start pulse, m_ready=1 -> m_valid from cycle 1 to cycle 15; m_data/m_index = 0..14; m_last only on index 14; done at cycle 16; checksum = 105.
- Same frame, m_ready toggling 1,0,0,1,... -> every index 0..14 appears exactly once, data stable during stalls, checksum = 105.
- All words = 0xF, start; change y_flat to 0 on the cycle after capture -> all 15 transfers carry 0xF; checksum = 225.
- Second start asserted at index 5, then a new start asserted in the done cycle with all words = 1 -> the first is ignored; the second frame follows immediately; checksum = 15 after it completes.
- abort after 3 transfers of the k-frame -> m_valid low the next cycle, no done, checksum = 3 (0+1+2), busy=0.
- rst_n pulled low asynchronously at index 7 -> all outputs 0 immediately; after release no m_valid appears until a new start.

Source files
------------

// File: rtl/conv_result_serializer.sv
// Captures one frame of parallel convolution results and streams it out one word
// per valid/ready transfer, with word index, last flag and a running checksum.
module conv_result_serializer #(
    parameter int N_OUT = 15,
    parameter int W     = 4,
    parameter int IDX_W = 4,
    parameter int CK_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_OUT*W-1:0] y_flat,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [W-1:0]       m_data,
    output logic [IDX_W-1:0]   m_index,
    output logic               m_last,
    output logic               done,
    output logic [CK_W-1:0]    checksum,
    output logic               dbg_state_o
);

    // Handshake: a word moves when m_valid && m_ready at a rising edge; while
    // m_valid is high and m_ready low, m_data/m_index/m_last hold unchanged.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    state_e             state_q, state_d;
    logic [N_OUT*W-1:0] cap_q, cap_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CK_W-1:0]    ck_q, ck_d;
    logic               done_q, done_d;

    logic               sending;
    logic               is_last;
    logic [W-1:0]       cur_word;

    assign sending  = (state_q == S_SEND);
    assign is_last  = (idx_q == LAST_IDX);
    assign cur_word = cap_q[int'(idx_q)*W +: W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cap_q   <= '0;
            idx_q   <= '0;
            ck_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            idx_q   <= idx_d;
            ck_q    <= ck_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        idx_d   = idx_q;
        ck_d    = ck_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // abort outranks start, so a simultaneous pair captures nothing
                if (start && !abort) begin
                    cap_d   = y_flat;
                    idx_d   = '0;
                    ck_d    = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (m_ready) begin
                    ck_d = ck_q + CK_W'(cur_word);
                    if (is_last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = sending;
    assign m_valid     = sending;
    assign m_data      = sending ? cur_word : '0;
    assign m_index     = sending ? idx_q : '0;
    assign m_last      = sending && is_last;
    assign done        = done_q;
    assign checksum    = ck_q;
    assign dbg_state_o = state_q;

endmodule
